// File: rtl/tiny_dnn_pkg.sv
// Shared types for the tiny_dnn command sequencer: host op codes, FSM states
// and the bfloat16 1.0 constant.
package tiny_dnn_pkg;

    typedef enum logic [1:0] {
        OP_LOAD     = 2'd0,
        OP_RUN      = 2'd1,
        OP_READBACK = 2'd2,
        OP_RSVD     = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD     = 4'd1,
        S_INIT     = 4'd2,
        S_RUN      = 4'd3,
        S_DRAIN    = 4'd4,
        S_NORM     = 4'd5,
        S_CAPT     = 4'd6,
        S_RD_ISSUE = 4'd7,
        S_RD_WAIT  = 4'd8,
        S_RESP     = 4'd9
    } state_e;

    localparam logic [15:0] BF16_ONE = 16'h3F80;

endpackage

// File: rtl/tiny_dnn_seq.sv
// Command sequencer driving one tiny_dnn_core + normalize pair from a host stream.
// Optional weight read-back path is enabled by defining TINY_DNN_SEQ_READBACK_EN.
module tiny_dnn_seq
    import tiny_dnn_pkg::*;
#(
    parameter int unsigned F_SIZE = 512,
    parameter int unsigned AW     = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW:0]   cmd_len,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [15:0]   s_data,
    output logic          r_valid,
    input  logic          r_ready,
    output logic [31:0]   r_data,
    output logic          core_write,
    output logic          core_read,
    output logic          core_init,
    output logic          core_exec,
    output logic [AW-1:0] core_a,
    output logic [15:0]   core_d,
    input  logic          core_busy,
    input  logic [15:0]   core_w,
    output logic          nrm_en,
    input  logic [31:0]   nrm
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(F_SIZE);

    state_e      state, state_d;
    op_e         op, op_d;
    logic [AW:0] cnt, cnt_d;
    logic [AW:0] len, len_d;
    logic        r_valid_d;
    logic [31:0] r_data_d;
    logic [AW:0] cmd_len_cl;
    logic [AW:0] cnt_inc;

    assign cmd_len_cl = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign cnt_inc    = cnt + (AW+1)'(1);

`ifndef TINY_DNN_SEQ_READBACK_EN
    logic unused_core_w;
    assign unused_core_w = ^core_w;
`endif

    // State register and registered result stream
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            op      <= OP_LOAD;
            cnt     <= '0;
            len     <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            state   <= state_d;
            op      <= op_d;
            cnt     <= cnt_d;
            len     <= len_d;
            r_valid <= r_valid_d;
            r_data  <= r_data_d;
        end
    end

    // Next-state, counters and core strobes
    always_comb begin
        state_d    = state;
        op_d       = op;
        cnt_d      = cnt;
        len_d      = len;
        r_valid_d  = r_valid;
        r_data_d   = r_data;
        cmd_ready  = 1'b0;
        s_ready    = 1'b0;
        core_write = 1'b0;
        core_read  = 1'b0;
        core_init  = 1'b0;
        core_exec  = 1'b0;
        core_a     = '0;
        core_d     = '0;
        nrm_en     = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_ready = !reset;
                if (!reset && cmd_valid) begin
                    op_d  = op_e'(cmd_op);
                    len_d = cmd_len_cl;
                    cnt_d = '0;
                    case (op_e'(cmd_op))
                        OP_LOAD:     state_d = (cmd_len_cl == '0) ? S_IDLE : S_LOAD;
                        OP_RUN:      state_d = S_INIT;
`ifdef TINY_DNN_SEQ_READBACK_EN
                        OP_READBACK: state_d = (cmd_len_cl == '0) ? S_IDLE : S_RD_ISSUE;
`endif
                        default:     state_d = S_IDLE;
                    endcase
                end
            end

            S_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    core_write = 1'b1;
                    core_a     = cnt[AW-1:0];
                    core_d     = s_data;
                    cnt_d      = cnt_inc;
                    if (cnt_inc == len) state_d = S_IDLE;
                end
            end

            // Clears the core accumulator before each dot product
            S_INIT: begin
                core_init = 1'b1;
                state_d   = (len == '0) ? S_DRAIN : S_RUN;
            end

            S_RUN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    core_exec = 1'b1;
                    core_a    = cnt[AW-1:0];
                    core_d    = s_data;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == len) state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (!core_busy) state_d = S_NORM;
            end

            S_NORM: begin
                nrm_en  = 1'b1;
                state_d = S_CAPT;
            end

            S_CAPT: begin
                r_data_d  = nrm;
                r_valid_d = 1'b1;
                state_d   = S_RESP;
            end

`ifdef TINY_DNN_SEQ_READBACK_EN
            S_RD_ISSUE: begin
                core_read = 1'b1;
                core_a    = cnt[AW-1:0];
                state_d   = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                r_data_d  = {16'h0, core_w};
                r_valid_d = 1'b1;
                state_d   = S_RESP;
            end
`endif

            // Read-back walks the address range one response at a time
            S_RESP: begin
                if (r_ready) begin
                    r_valid_d = 1'b0;
                    if (op == OP_READBACK) begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc < len) ? S_RD_ISSUE : S_IDLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Directed bench for tiny_dnn_seq with a behavioural core + normalize model.
module tb_tiny_dnn_seq;
    import tiny_dnn_pkg::*;

    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW:0]   cmd_len = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [15:0]   s_data = '0;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic [31:0]   r_data;
    logic          core_write, core_read, core_init, core_exec;
    logic [AW-1:0] core_a;
    logic [15:0]   core_d;
    logic          core_busy;
    logic [15:0]   core_w = '0;
    logic          nrm_en;
    logic [31:0]   nrm = '0;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    tiny_dnn_seq #(.F_SIZE(512), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .core_write(core_write), .core_read(core_read), .core_init(core_init),
        .core_exec(core_exec), .core_a(core_a), .core_d(core_d),
        .core_busy(core_busy), .core_w(core_w), .nrm_en(nrm_en), .nrm(nrm)
    );

    always #5 clk = ~clk;

    function automatic real bf2real(input logic [15:0] b);
        real v;
        int  e;
        if (b[14:0] == 15'h0) return 0.0;
        v = 1.0 + real'(b[6:0]) / 128.0;
        e = int'(b[14:7]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[15] ? -v : v;
    endfunction

    function automatic logic [31:0] real2f32(input real r);
        logic s;
        int   e;
        real  m;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    // Behavioural core: weight memory, MAC accumulator, busy while exec is in flight
    logic [15:0] mem [0:511];
    real         acc = 0.0;
    int          exec_cnt = 0, init_cnt = 0, write_cnt = 0, read_cnt = 0;
    int          addr_err = 0, zero_err = 0, rhs_cnt = 0;
    int          exec_log[$];

    assign core_busy = core_exec;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_write) begin
            mem[core_a] <= core_d;
            if (int'(core_a) != write_cnt) addr_err <= addr_err + 1;
            write_cnt <= write_cnt + 1;
        end
        if (core_read) begin
            core_w   <= mem[core_a];
            read_cnt <= read_cnt + 1;
        end
        if (core_init) begin
            acc      <= 0.0;
            init_cnt <= init_cnt + 1;
        end
        if (core_exec) begin
            acc      <= acc + bf2real(mem[core_a]) * bf2real(core_d);
            exec_cnt <= exec_cnt + 1;
            exec_log.push_back(int'(core_a));
        end
        if (nrm_en) nrm <= real2f32(acc);
        if (!core_write && !core_exec && !core_read && core_a != '0) zero_err <= zero_err + 1;
        if (!core_write && !core_exec && core_d != '0) zero_err <= zero_err + 1;
        if (r_valid && r_ready) rhs_cnt <= rhs_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input int len);
        int n = 0;
        cmd_op    = op;
        cmd_len   = (AW+1)'(len);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) check("cmd_timeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, output int hs);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 100) begin @(negedge clk); n++; end
        if (!s_ready) check("s_timeout", 32'd0, 32'd1);
        hs = cyc;
        @(negedge clk);
    endtask

    task automatic wait_rv(output int c);
        int n = 0;
        while (!r_valid && n < 64) begin @(negedge clk); n++; end
        if (!r_valid) check("rv_timeout", 32'd0, 32'd1);
        c = cyc;
    endtask

    // Hold r_ready low for some cycles checking stability, then accept
    task automatic take_resp(input string tag, input logic [31:0] exp, input int hold);
        check(tag, r_data, exp);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_v"}, 32'(r_valid), 32'd1);
            check({tag, "_hold_d"}, r_data, exp);
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    task automatic load_words(input int len, input logic [15:0] d0, d1, d2);
        logic [15:0] d [3];
        int hs;
        d = '{d0, d1, d2};
        send_cmd(OP_LOAD, len);
        for (int i = 0; i < len; i++) send_word(d[i], hs);
        s_valid = 1'b0;
    endtask

    task automatic do_run(input string tag, input int len, input logic [15:0] d0, d1, d2,
                          input int gap, input logic [31:0] exp);
        logic [15:0] d [3];
        int hs = 0, rc, e0, i0;
        d  = '{d0, d1, d2};
        e0 = exec_cnt;
        i0 = init_cnt;
        exec_log.delete();
        send_cmd(OP_RUN, len);
        for (int i = 0; i < len; i++) begin
            send_word(d[i], hs);
            if (gap > 0 && i < len - 1) begin
                s_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        s_valid = 1'b0;
        wait_rv(rc);
        if (len > 0 && gap == 0) check({tag, "_latency"}, 32'(rc - hs), 32'd4);
        check({tag, "_execs"}, 32'(exec_cnt - e0), 32'(len));
        check({tag, "_inits"}, 32'(init_cnt - i0), 32'd1);
        take_resp({tag, "_data"}, exp, 1);
        check({tag, "_rv_clr"}, 32'(r_valid), 32'd0);
    endtask

    initial begin
        int hs, rc, r0, rd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_strobes", {28'd0, core_write, core_read, core_init, core_exec}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_r_data", r_data, 32'd0);

        // Weights {1,2,0}; 1*2 + 2*1 = 4.0
        load_words(3, BF16_ONE, 16'h4000, 16'h0000);
        check("load3_writes", 32'(write_cnt), 32'd3);
        do_run("run2", 2, 16'h4000, BF16_ONE, 16'h0, 0, 32'h40800000);

`ifdef TINY_DNN_SEQ_READBACK_EN
        r0 = rhs_cnt;
        send_cmd(OP_READBACK, 2);
        wait_rv(rc);
        take_resp("rb0", 32'h00003F80, 3);
        wait_rv(rc);
        take_resp("rb1", 32'h00004000, 3);
        repeat (3) @(negedge clk);
        check("rb_handshakes", 32'(rhs_cnt - r0), 32'd2);
        check("rb_idle", 32'(cmd_ready), 32'd1);
`else
        rd0 = rhs_cnt;
        send_cmd(2'd2, 2);
        repeat (5) begin
            check("rb_off_no_rv", 32'(r_valid), 32'd0);
            @(negedge clk);
        end
        check("rb_off_no_read", 32'(read_cnt), 32'd0);
        check("rb_off_no_hs", 32'(rhs_cnt - rd0), 32'd0);
`endif

        // Empty dot product still produces a (zero) result
        do_run("run0", 0, 16'h0, 16'h0, 16'h0, 0, 32'h00000000);

        // 2 + 2 + 0 = 4.0, back-to-back then with 2-cycle gaps
        do_run("run3", 3, 16'h4000, BF16_ONE, 16'h4000, 0, 32'h40800000);
        do_run("run3gap", 3, 16'h4000, BF16_ONE, 16'h4000, 2, 32'h40800000);
        check("gap_log_n", 32'(exec_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < exec_log.size()) check("gap_addr", 32'(exec_log[i]), 32'(i));

        // Reset abandons a RUN; the next RUN must start from a cleared accumulator
        send_cmd(OP_RUN, 3);
        send_word(16'h4000, hs);
        s_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst_r_valid", 32'(r_valid), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("postrst_idle", 32'(cmd_ready), 32'd1);
        do_run("run1", 1, 16'h4000, 16'h0, 16'h0, 0, 32'h40000000);

        // Reserved op: accepted, no result
        rd0 = rhs_cnt;
        send_cmd(OP_RSVD, 5);
        repeat (5) begin
            check("rsvd_no_rv", 32'(r_valid), 32'd0);
            @(negedge clk);
        end
        check("rsvd_idle", 32'(cmd_ready), 32'd1);

        // Oversized LOAD clamps to 512 words, addresses 0..511
        write_cnt = 0;
        addr_err  = 0;
        send_cmd(OP_LOAD, 600);
        s_valid = 1'b1;
        for (int i = 0; i < 530; i++) begin
            s_data = 16'(i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("clamp_writes", 32'(write_cnt), 32'd512);
        check("clamp_addr_err", 32'(addr_err), 32'd0);
        check("clamp_idle", 32'(cmd_ready), 32'd1);
        check("clamp_w511", 32'(mem[511]), 32'd511);
        check("zero_when_idle", 32'(zero_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/tiny_dnn_seq.md
Name: tiny_dnn_seq

Overview:
Command sequencer that drives the tiny_dnn_core command port (write/read/init/exec/a/d) from a host-side stream interface. It loads bfloat16 weights into the core's weight memory and runs dot products by streaming bfloat16 activations. It drains the FMA pipeline, pulses the normalize stage, and returns the float32 result (or read-back weights) on a ready/valid result stream. It sits between the host/DMA interface and one tiny_dnn_core + normalize pair.

Parameters:
F_SIZE, 512, weight memory depth; must match the core's f_size.
AW, 9, address width, $clog2(F_SIZE).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when both high; high only in IDLE
cmd_op  in  2  0=LOAD, 1=RUN, 2=READBACK, 3=reserved (accepted, no-op)
cmd_len  in  AW+1  word count, 0..F_SIZE
s_valid  in  1  data word valid (weights or activations)
s_ready  out  1  data word accepted
s_data  in  16  bfloat16 data
r_valid  out  1  result valid
r_ready  in  1  result accepted
r_data  out  32  float32 result, or {16'h0,weight} for READBACK
core_write  out  1  to core write
core_read  out  1  to core read
core_init  out  1  to core init
core_exec  out  1  to core exec
core_a  out  AW  to core address
core_d  out  16  to core data
core_busy  in  1  from core busy
core_w  in  16  from core w
nrm_en  out  1  to normalize en
nrm  in  32  from normalize nrm

Behaviour:
- Reset: state=IDLE, cnt=0, r_valid=0, r_data=0, all core_* and nrm_en=0, s_ready=0, cmd_ready=0. Reset mid-operation abandons the command. Core memory is not cleared, and the accumulator is cleared on the next RUN.
- States: IDLE, LOAD, INIT, RUN, DRAIN, NORM, CAPT, RD_ISSUE, RD_WAIT, RESP.
- IDLE: cmd_ready=1; on handshake latch op/len and set cnt=0. LOAD->LOAD, RUN->INIT, READBACK->RD_ISSUE, reserved->IDLE. len=0: LOAD->IDLE, READBACK->IDLE, RUN->INIT (result still produced).
- LOAD: s_ready=1. Per s_valid cycle: core_write=1, core_a=cnt, core_d=s_data, cnt++. After the len-th word -> IDLE.
- INIT: core_init=1 for one cycle -> RUN, or DRAIN if len=0.
- RUN: s_ready=1. core_exec=s_valid, core_a=cnt, core_d=s_data. cnt++ on each accepted word. Gaps (s_valid=0) hold the address with exec low. After the len-th word -> DRAIN.
- DRAIN: wait while core_busy=1 (minimum one cycle after last exec) -> NORM.
- NORM: nrm_en=1 for one cycle -> CAPT.
- CAPT: r_data<=nrm, r_valid<=1 -> RESP.
- RD_ISSUE: core_read=1, core_a=cnt -> RD_WAIT. RD_WAIT: r_data<={16'h0,core_w}, r_valid<=1 -> RESP.
- RESP: hold r_valid/r_data until r_ready. Then r_valid<=0. For READBACK: cnt++, and go to RD_ISSUE if cnt<len, else IDLE. For RUN: go to IDLE.
- Latency for RUN with no stalls: len exec cycles + 1 INIT + 1 DRAIN + 1 NORM + 1 CAPT. r_valid rises 4 cycles after the last s handshake.
- s_ready is combinational from state only and never depends on s_valid. core_d and core_a are 0 when the corresponding strobe is low.
- cmd_len > F_SIZE is clamped to F_SIZE.

Optional Feature:
TINY_DNN_SEQ_READBACK_EN:
- Defined: READBACK op, RD_ISSUE and RD_WAIT are present, and core_read is driven.
- Undefined: core_read is tied 0, and op 2 behaves as reserved (accepted, returns to IDLE with no result).

Decomposition:
- Package tiny_dnn_pkg holds the op_e enum (LOAD, RUN, READBACK, RSVD), the state_e enum, and the BF16_ONE=16'h3F80 test constant.
- No sub-module needed: a single FSM plus counter. A core+normalize+seq wrapper belongs only in the testbench.

Test Plan:
- LOAD len=2 {3F80,4000}, then RUN len=2 {4000,3F80} -> r_data=32'h40800000 (4.0), r_valid 4 cycles after the last s handshake.
- READBACK len=2 after the above, r_ready held low 3 cycles -> r_data stable at 0000_3F80, then 0000_4000, with exactly 2 r handshakes.
- RUN len=0 -> core_init pulse, no core_exec, r_data=32'h00000000.
- RUN len=3 with s_valid low for 2 cycles between words -> core_exec asserted exactly 3 times at a=0,1,2, result unchanged vs. the no-gap run.
- Assert reset during RUN at word 1, then RUN len=1 with w[0]=3F80, d=4000 -> r_data=32'h40000000 (accumulator cleared by INIT).
- cmd_op=3 and cmd_len=600 LOAD -> reserved returns to IDLE with no r_valid; LOAD writes exactly 512 words (a 0..511).
